rtc_access_scheduler: RTL
=========================

Name: rtc_access_scheduler

Overview:
Sequences every access to the RTC protocol engine (multiplexed address/data bus with ChipSelect/Read/Write/AoD). After reset it issues one initialisation write. It then periodically scans the six time/date registers into a shadow register file for the VGA path. User edit writes (+1/-1 values) are slotted between scan reads. Each transaction is one start/done handshake, guarded by a timeout.

Parameters:
REFRESH_CYCLES, 100000, clk cycles between scan starts (1 ms at 100 MHz)
TIMEOUT_CYCLES, 255, max clk cycles from trans_start to trans_done before abort
INIT_ADDR, 8'h02, RTC control register written once after reset
INIT_DATA, 8'h10, value written to INIT_ADDR

Ports:
clk  in  1  100 MHz system clock
reset  in  1  synchronous, active-high reset
wr_req  in  1  user write request, held until wr_ack
wr_addr  in  8  RTC register address for user write
wr_data  in  8  BCD data for user write
wr_ack  out  1  one-cycle pulse when the user write completes or aborts
trans_start  out  1  one-cycle pulse to the protocol engine, starts a transaction
trans_rw  out  1  1 = read (IndicadorMaquina=1), 0 = write; stable from start to done
trans_addr  out  8  address to protocol engine; stable from start to done
trans_wdata  out  8  write data to protocol engine; stable from start to done
trans_done  in  1  one-cycle pulse from the engine at end of transaction
trans_rdata  in  8  read data, valid in the trans_done cycle when trans_rw=1
seg, min, hora, dia, mes, anio  out  8 each  shadow BCD time/date registers
scan_valid  out  1  one-cycle pulse after all six shadow registers are updated
busy  out  1  high when any transaction is in flight
error  out  1  sticky flag: a transaction timed out

Behaviour:
- Reset values:
  - all shadow registers 8'h00; wr_ack, trans_start, scan_valid, busy, error = 0
  - trans_rw = 1, trans_addr = 8'h00, trans_wdata = 8'h00
  - refresh counter = REFRESH_CYCLES-1; state = INIT_ISSUE
- FSM states:
  - INIT_ISSUE: pulse trans_start with rw=0, INIT_ADDR, INIT_DATA -> INIT_WAIT.
  - INIT_WAIT: on trans_done or timeout -> IDLE.
  - IDLE, in priority order:
    - wr_req=1 -> WR_ISSUE.
    - refresh counter = 0 -> RD_ISSUE with scan index 0.
    - otherwise stay.
  - RD_ISSUE: pulse trans_start, rw=1, addr = SCAN_ADDR[idx] -> RD_WAIT.
  - RD_WAIT: on trans_done, capture trans_rdata into shadow[idx] in that same cycle.
    - idx<5: if wr_req -> WR_ISSUE (resume flag set), else idx+1 -> RD_ISSUE.
    - idx=5: pulse scan_valid next cycle -> IDLE.
  - WR_ISSUE: pulse trans_start, rw=0, wr_addr/wr_data latched at issue -> WR_WAIT.
  - WR_WAIT: on done or timeout, pulse wr_ack.
    - resume flag set: clear it, idx+1 -> RD_ISSUE.
    - otherwise -> IDLE.
- Latency:
  - trans_start is asserted the cycle after entering an ISSUE state.
  - Shadow registers update one cycle after trans_done.
- Refresh counter:
  - Free-running down-counter, reloaded to REFRESH_CYCLES-1 at zero.
  - If zero is hit while not IDLE, a pending-scan bit is set and serviced at the next IDLE. Only one pending scan is held; further hits are dropped.
- Timeout counter:
  - Cleared at each trans_start; increments in any WAIT state.
  - When it reaches TIMEOUT_CYCLES: set error, abort the transaction, and proceed as if done. A timed-out read leaves its shadow register unchanged.
- Handshake rules:
  - trans_done outside a WAIT state is ignored.
  - A second trans_start is never issued before done or timeout.
  - wr_req falling before wr_ack is ignored once WR_ISSUE is entered.
- Simultaneous events:
  - wr_req and refresh zero in IDLE: the write goes first, and the scan stays pending.
  - trans_done in the same cycle as timeout: treated as done, and error is not set.
- Reset mid-operation: returns to INIT_ISSUE and reissues the init write. The protocol engine is reset by the same signal.
- busy = 1 from the trans_start cycle through the done or abort cycle.

Decomposition:
- Package rtc_pkg holds:
  - address constants: ADDR_SEG=8'h21, ADDR_MIN=8'h22, ADDR_HORA=8'h23, ADDR_DIA=8'h24, ADDR_MES=8'h25, ADDR_ANIO=8'h26, ADDR_CMD=8'hF0
  - scan table SCAN_ADDR[0..5] in the order seg, min, hora, dia, mes, anio
  - FSM state encoding
- One sub-module: rtc_timeout_counter (clear/enable/expired).

Test Plan:
- Reset release, engine model answers done after 40 cycles -> first transaction is rw=0 addr 8'h02 data 8'h10; busy high for 41 cycles; then IDLE.
- Model returns 8'h59, 8'h30, 8'h12, 8'h15, 8'h06, 8'h24 for the scan -> reads issued to 21..26 in order; shadow registers equal those values; scan_valid pulses once.
- wr_req (addr 8'h22, data 8'h31) raised during the read of 8'h22 -> the write is issued after that read completes, wr_ack pulses, the scan resumes at 8'h23, and min ends at the value read before the write.
- wr_req and refresh zero in the same IDLE cycle -> write first, then scan starts immediately after wr_ack.
- Model never asserts done on the read of 8'h23 -> abort at TIMEOUT_CYCLES, error=1 and sticky, hora unchanged, scan continues to 8'h24.
- Reset asserted mid-RD_WAIT -> all outputs at reset values the next cycle; the init write is reissued.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants for the RTC access scheduler:
// register map, scan order and scheduler state encoding.
package rtc_pkg;

    localparam logic [7:0] ADDR_SEG  = 8'h21;
    localparam logic [7:0] ADDR_MIN  = 8'h22;
    localparam logic [7:0] ADDR_HORA = 8'h23;
    localparam logic [7:0] ADDR_DIA  = 8'h24;
    localparam logic [7:0] ADDR_MES  = 8'h25;
    localparam logic [7:0] ADDR_ANIO = 8'h26;
    localparam logic [7:0] ADDR_CMD  = 8'hF0;

    localparam logic [2:0] SCAN_LAST = 3'd5;

    // Element 0 is scanned first.
    localparam logic [5:0][7:0] SCAN_ADDR = {
        ADDR_ANIO, ADDR_MES, ADDR_DIA,
        ADDR_HORA, ADDR_MIN, ADDR_SEG
    };

    typedef enum logic [2:0] {
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_WR_WAIT
    } state_e;

endpackage

// File: rtl/rtc_timeout_counter.sv
// Watchdog for one engine transaction: counts wait cycles
// and flags expiry once the limit is reached.
module rtc_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_access_scheduler.sv
// Serialises init write, periodic shadow scans and user edit
// writes onto the single start/done RTC engine port.
module rtc_access_scheduler
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  INIT_ADDR      = 8'h02,
    parameter logic [7:0]  INIT_DATA      = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       trans_start,
    output logic       trans_rw,
    output logic [7:0] trans_addr,
    output logic [7:0] trans_wdata,
    input  logic       trans_done,
    input  logic [7:0] trans_rdata,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic       scan_valid,
    output logic       busy,
    output logic       error
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] RELOAD = RW'(REFRESH_CYCLES - 1);

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            resume_q, resume_d;
    logic            pend_q, pend_d;
    logic [RW-1:0]   ref_q, ref_d;
    logic            start_q, start_d;
    logic            rw_q, rw_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            ack_q, ack_d;
    logic            sv_q, sv_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [5:0][7:0] shadow_q, shadow_d;

    logic in_wait, in_issue, expired;
    logic finish, abort, req, ref_zero;

    assign in_wait  = state_q inside {S_INIT_WAIT, S_RD_WAIT, S_WR_WAIT};
    assign in_issue = state_q inside {S_INIT_ISSUE, S_RD_ISSUE, S_WR_ISSUE};
    // A done arriving on the expiry cycle wins over the abort.
    assign finish   = in_wait && (trans_done || expired);
    assign abort    = in_wait && expired && !trans_done;
    // The ack cycle already counts as the request being withdrawn.
    assign req      = wr_req && !ack_q;
    assign ref_zero = (ref_q == '0);

    rtc_timeout_counter #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (in_issue),
        .enable  (in_wait),
        .expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        resume_d = resume_q;
        pend_d   = pend_q | ref_zero;
        ref_d    = ref_zero ? RELOAD : ref_q - 1'b1;
        start_d  = 1'b0;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        sv_d     = 1'b0;
        busy_d   = busy_q && !finish;
        err_d    = err_q || abort;
        shadow_d = shadow_q;
        unique case (state_q)
            S_INIT_ISSUE: begin
                start_d = 1'b1;
                busy_d  = 1'b1;
                rw_d    = 1'b0;
                addr_d  = INIT_ADDR;
                wdata_d = INIT_DATA;
                state_d = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (finish) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req) begin
                    state_d = S_WR_ISSUE;
                end else if (pend_d) begin
                    pend_d  = 1'b0;
                    idx_d   = '0;
                    state_d = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                start_d = 1'b1;
                busy_d  = 1'b1;
                rw_d    = 1'b1;
                addr_d  = SCAN_ADDR[idx_q];
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (finish) begin
                    if (!abort) shadow_d[idx_q] = trans_rdata;
                    if (idx_q == SCAN_LAST) begin
                        sv_d    = 1'b1;
                        state_d = S_IDLE;
                    end else if (req) begin
                        resume_d = 1'b1;
                        state_d  = S_WR_ISSUE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_WR_ISSUE: begin
                start_d = 1'b1;
                busy_d  = 1'b1;
                rw_d    = 1'b0;
                addr_d  = wr_addr;
                wdata_d = wr_data;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (finish) begin
                    ack_d = 1'b1;
                    if (resume_q) begin
                        resume_d = 1'b0;
                        idx_d    = idx_q + 1'b1;
                        state_d  = S_RD_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_INIT_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_INIT_ISSUE;
            idx_q    <= '0;
            resume_q <= 1'b0;
            pend_q   <= 1'b0;
            ref_q    <= RELOAD;
            start_q  <= 1'b0;
            rw_q     <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            sv_q     <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            resume_q <= resume_d;
            pend_q   <= pend_d;
            ref_q    <= ref_d;
            start_q  <= start_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            sv_q     <= sv_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
        end
    end

    assign wr_ack      = ack_q;
    assign trans_start = start_q;
    assign trans_rw    = rw_q;
    assign trans_addr  = addr_q;
    assign trans_wdata = wdata_q;
    assign scan_valid  = sv_q;
    assign busy        = busy_q;
    assign error       = err_q;
    assign seg         = shadow_q[0];
    assign min         = shadow_q[1];
    assign hora        = shadow_q[2];
    assign dia         = shadow_q[3];
    assign mes         = shadow_q[4];
    assign anio        = shadow_q[5];

endmodule
